// File: rtl/clock_pkg.sv
// clock_pkg: BCD digit/pair types, FSM states and field limits shared by the
// time-of-day counter and its digit counters.
package clock_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [7:0] bcd_pair_t;

    typedef enum logic [1:0] {
        ST_STOP,
        ST_RUN,
        ST_CHECK
    } tod_state_e;

    localparam bcd_pair_t SEC_MAX  = 8'h59;
    localparam bcd_pair_t MIN_MAX  = 8'h59;
    localparam bcd_pair_t HOUR_MAX = 8'h23;

    // Both nibbles must be decimal digits before the packed compare means anything.
    function automatic logic bcd_in_range(bcd_pair_t v, bcd_pair_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd_pair_t bcd_inc(bcd_pair_t v);
        bcd_digit_t tens;
        bcd_digit_t units;
        tens  = v[7:4];
        units = v[3:0];
        return (units == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// bcd_wrap_counter: two-digit packed BCD counter that wraps max->00 with a
// carry-out; a load takes priority over an increment.
module bcd_wrap_counter
    import clock_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_inc,
    input  logic      i_load,
    input  bcd_pair_t i_load_val,
    input  bcd_pair_t i_max,
    output bcd_pair_t o_q,
    output logic      o_carry
);

    bcd_pair_t q_next;

    assign o_carry = i_inc && !i_load && (o_q == i_max);

    always_comb begin
        q_next = o_q;
        q_next = i_load ? i_load_val : o_carry ? '0 : i_inc ? bcd_inc(o_q) : o_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_q <= '0;
        else       o_q <= q_next;
    end

endmodule

// File: rtl/time_of_day_counter.sv
// time_of_day_counter: 24-hour BCD clock with a validated set handshake.
// Define TOD_ALARM_EN to add the hh:mm alarm ports and o_alarm pulse.
module time_of_day_counter
    import clock_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_tick,
    input  logic      i_en,
    input  logic      i_set_valid,
    input  bcd_pair_t i_set_hh,
    input  bcd_pair_t i_set_mm,
    input  bcd_pair_t i_set_ss,
    output logic      o_set_ready,
    output logic      o_set_err,
    output bcd_pair_t o_hh,
    output bcd_pair_t o_mm,
    output bcd_pair_t o_ss,
    output logic      o_min_tick,
    output logic      o_day_tick
`ifdef TOD_ALARM_EN
    ,
    input  logic      i_alm_arm,
    input  bcd_pair_t i_alm_hh,
    input  bcd_pair_t i_alm_mm,
    output logic      o_alarm
`endif
);

    tod_state_e state;
    tod_state_e state_next;
    logic       alive;
    logic       hs;
    logic       valid;
    logic       load;
    logic       tick_en;
    logic       ss_carry;
    logic       mm_carry;
    logic       hh_carry;
    bcd_pair_t  hold_hh;
    bcd_pair_t  hold_mm;
    bcd_pair_t  hold_ss;

    // alive keeps o_set_ready low until the first clock edge after reset release.
    assign o_set_ready = alive && (state != ST_CHECK);
    assign hs          = i_set_valid && o_set_ready;
    assign valid       = bcd_in_range(hold_hh, HOUR_MAX) && bcd_in_range(hold_mm, MIN_MAX) &&
                         bcd_in_range(hold_ss, SEC_MAX);
    assign load        = (state == ST_CHECK) && valid;
    assign tick_en     = i_tick && i_en && (state == ST_RUN) && !hs;

    always_comb begin
        state_next = state;
        state_next = hs ? ST_CHECK : i_en ? ST_RUN : ST_STOP;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= ST_STOP;
            alive      <= 1'b0;
            hold_hh    <= '0;
            hold_mm    <= '0;
            hold_ss    <= '0;
            o_set_err  <= 1'b0;
            o_min_tick <= 1'b0;
            o_day_tick <= 1'b0;
        end else begin
            state      <= state_next;
            alive      <= 1'b1;
            o_set_err  <= (state == ST_CHECK) && !valid;
            o_min_tick <= ss_carry;
            o_day_tick <= hh_carry;
            if (hs) begin
                hold_hh <= i_set_hh;
                hold_mm <= i_set_mm;
                hold_ss <= i_set_ss;
            end
        end
    end

    bcd_wrap_counter u_ss (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (tick_en),
        .i_load     (load),
        .i_load_val (hold_ss),
        .i_max      (SEC_MAX),
        .o_q        (o_ss),
        .o_carry    (ss_carry)
    );

    bcd_wrap_counter u_mm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (ss_carry),
        .i_load     (load),
        .i_load_val (hold_mm),
        .i_max      (MIN_MAX),
        .o_q        (o_mm),
        .o_carry    (mm_carry)
    );

    bcd_wrap_counter u_hh (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_inc      (mm_carry),
        .i_load     (load),
        .i_load_val (hold_hh),
        .i_max      (HOUR_MAX),
        .o_q        (o_hh),
        .o_carry    (hh_carry)
    );

`ifdef TOD_ALARM_EN
    // o_min_tick only follows a counted second, so a set load never fires the alarm.
    assign o_alarm = o_min_tick && i_alm_arm && (o_hh == i_alm_hh) && (o_mm == i_alm_mm);
`endif

endmodule

// File: doc/time_of_day_counter.md
TIME_OF_DAY_COUNTER -- requirements
Module: time_of_day_counter

Interface
REQ-001 Parameters: none; 24-hour format is fixed.
REQ-002 i_clk  in  1  system clock, 50 MHz, the same clock as the 1 pulse-per-second generator.
REQ-003 i_rst  in  1  reset, asynchronous, active-high.
REQ-004 i_tick  in  1  one-cycle 1 Hz pulse from the 1 pulse-per-second generator.
REQ-005 i_en  in  1  run enable; 0 = time frozen.
REQ-006 i_set_valid  in  1  set request; held until accepted.
REQ-007 i_set_hh / i_set_mm / i_set_ss  in  8 each  packed BCD set value (tens[7:4], units[3:0]).
REQ-008 o_set_ready  out  1  high only in STOP or RUN.
REQ-009 o_set_err  out  1  one-cycle pulse: a set value was rejected.
REQ-010 o_hh / o_mm / o_ss  out  8 each  current time, packed BCD.
REQ-011 o_min_tick / o_day_tick  out  1  one-cycle pulse on :59->:00 second wrap / 23:59:59->00:00:00 wrap.

Function
REQ-012 FSM states: STOP, RUN, CHECK.
- STOP->RUN when i_en=1.
- RUN->STOP when i_en=0.
- STOP/RUN->CHECK on handshake (i_set_valid & o_set_ready).
- CHECK->RUN if i_en=1, else STOP.
REQ-013 On handshake in cycle N, set values are captured into holding registers in cycle N.
REQ-014 In CHECK (cycle N+1), the captured values are validated:
- every BCD nibble <= 9;
- ss <= 0x59, mm <= 0x59, hh <= 0x23.
REQ-015 A valid set value is loaded at the end of CHECK; o_hh/o_mm/o_ss show it from cycle N+2.
REQ-016 An invalid set value leaves the time unchanged and pulses o_set_err in cycle N+2.
REQ-017 i_tick in RUN with i_en=1 advances the time by one second; the new value is visible the next cycle.
REQ-018 i_tick is ignored in STOP and CHECK, and in the handshake cycle: load wins, no catch-up.
REQ-019 Units digit wraps 9->0 and carries into the tens digit; seconds and minutes wrap 59->00 and carry upward; hours wrap 23->00.
REQ-020 o_min_tick is asserted in the same cycle as the updated 00-second value; on full wrap, o_min_tick and o_day_tick assert together.
REQ-021 o_set_err, o_min_tick and o_day_tick are never high for more than one cycle.

Reset
REQ-022 i_rst asserted at any time, including during CHECK, forces immediately:
- state STOP, time 00:00:00;
- o_set_ready=0, o_set_err=0, o_min_tick=0, o_day_tick=0;
- holding registers cleared; a captured but unloaded set value is discarded.
REQ-023 After reset release, o_set_ready rises in the first cycle in STOP, i.e. the cycle after deassertion.

Configuration
REQ-024 Macro TOD_ALARM_EN defined:
- adds ports i_alm_arm (1), i_alm_hh (8) and i_alm_mm (8), all BCD;
- adds output o_alarm (1): one-cycle pulse when the time becomes hh:mm:00 equal to the alarm value while i_alm_arm=1;
- a set load that lands exactly on the alarm time does not pulse o_alarm.
REQ-025 Macro TOD_ALARM_EN undefined: alarm ports and logic are absent; all other behaviour is identical.

Structure
REQ-026 Shared package clock_pkg holds:
- the BCD digit typedef (4 bits) and BCD pair typedef (8 bits);
- the FSM state enum;
- constants SEC_MAX=0x59, MIN_MAX=0x59, HOUR_MAX=0x23.
REQ-027 Sub-module bcd_wrap_counter: 2-digit BCD counter with an increment input, load, max-value input, and carry-out on wrap.
REQ-028 time_of_day_counter instantiates bcd_wrap_counter three times (ss, mm, hh) plus the FSM, the validator and, optionally, the alarm comparator.

Verification
REQ-029 Reset release, i_en=1, 3 i_tick pulses -> o_ss=0x03, o_mm=0x00, o_hh=0x00, no tick pulses.
REQ-030 Set 23:59:58, valid, i_en=1, 2 i_tick pulses -> 23:59:59, then 00:00:00 with o_min_tick=1 and o_day_tick=1 for exactly one cycle.
REQ-031 Set with ss=0x60, then with mm=0x4A -> o_set_err pulses twice, time unchanged, o_set_ready returns 1 two cycles after each handshake.
REQ-032 i_tick coincident with handshake of 12:00:00 -> time reads 0x12:0x00:0x00 at N+2, not 12:00:01; i_en=0 then 5 ticks -> no change.
REQ-033 i_rst pulse during CHECK of 10:10:10 -> time 00:00:00, no o_set_err, o_set_ready=1 the cycle after release.
REQ-034 With TOD_ALARM_EN, alarm 07:30 armed, time set 07:29:58, 2 i_tick pulses -> o_alarm one-cycle pulse at 07:30:00; disarmed rerun -> no pulse.
